wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_if.sv | 52 +++++
 rtl/wb_arbiter.sv | 113 +++++++++++
 tb/tb_wb_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if
//   Bundles the three Wishbone ports of the cache/memory arbiter.
//   I_*  instruction-cache master port (request in, ACK/RTY/DAT_S out)
//   D_*  data-cache master port        (request in, ACK/RTY/DAT_S out)
//   M_*  memory-side port              (request out, ACK/RTY/DAT_S in)
//   modport slave  : the arbiter's view (it is the slave of both caches)
//   modport master : the surrounding environment's view
interface wb_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    localparam int SEL_W = DATA_W / 8;

    logic              I_CYC, I_STB, I_WE;
    logic [ADDR_W-1:0] I_ADR;
    logic [DATA_W-1:0] I_DAT_M;
    logic [SEL_W-1:0]  I_SEL;
    logic              I_ACK, I_RTY;
    logic [DATA_W-1:0] I_DAT_S;

    logic              D_CYC, D_STB, D_WE;
    logic [ADDR_W-1:0] D_ADR;
    logic [DATA_W-1:0] D_DAT_M;
    logic [SEL_W-1:0]  D_SEL;
    logic              D_ACK, D_RTY;
    logic [DATA_W-1:0] D_DAT_S;

    logic              M_CYC, M_STB, M_WE;
    logic [ADDR_W-1:0] M_ADR;
    logic [DATA_W-1:0] M_DAT_M;
    logic [SEL_W-1:0]  M_SEL;
    logic              M_ACK, M_RTY;
    logic [DATA_W-1:0] M_DAT_S;

    modport slave (
        input  I_CYC, I_STB, I_WE, I_ADR, I_DAT_M, I_SEL,
        output I_ACK, I_RTY, I_DAT_S,
        input  D_CYC, D_STB, D_WE, D_ADR, D_DAT_M, D_SEL,
        output D_ACK, D_RTY, D_DAT_S,
        output M_CYC, M_STB, M_WE, M_ADR, M_DAT_M, M_SEL,
        input  M_ACK, M_RTY, M_DAT_S
    );

    modport master (
        output I_CYC, I_STB, I_WE, I_ADR, I_DAT_M, I_SEL,
        input  I_ACK, I_RTY, I_DAT_S,
        output D_CYC, D_STB, D_WE, D_ADR, D_DAT_M, D_SEL,
        input  D_ACK, D_RTY, D_DAT_S,
        input  M_CYC, M_STB, M_WE, M_ADR, M_DAT_M, M_SEL,
        output M_ACK, M_RTY, M_DAT_S
    );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter
//   Merges the instruction- and data-cache Wishbone masters onto one memory
//   port, one transaction at a time. Simultaneous requests are granted to
//   the master not served last. The granted master's request is muxed onto
//   M_* combinationally; M_ACK/M_RTY are routed back only to it.
//   Ports:
//     CLK  clock, rising edge
//     RST  asynchronous active-high reset
//     bus  wb_arbiter_if.slave (I_*, D_* cache ports, M_* memory port)
module wb_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic         CLK,
    input  logic         RST,
    wb_arbiter_if.slave  bus
);
    localparam int SEL_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

    state_t state, state_nxt;
    logic   last_d, last_d_nxt;   // 1: D was served most recently

    logic i_req, d_req;
    assign i_req = bus.I_CYC & bus.I_STB;
    assign d_req = bus.D_CYC & bus.D_STB;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            last_d <= 1'b0;   // I counts as last served, so a tie goes to D
        end else begin
            state  <= state_nxt;
            last_d <= last_d_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        last_d_nxt = last_d;
        case (state)
            IDLE: begin
                if (i_req && (!d_req || last_d)) begin
                    state_nxt  = GRANT_I;
                    last_d_nxt = 1'b0;
                end else if (d_req) begin
                    state_nxt  = GRANT_D;
                    last_d_nxt = 1'b1;
                end
            end
            // Completion (ACK/RTY) or abort (CYC dropped) ends the grant;
            // IDLE always lasts at least one cycle before the next grant.
            GRANT_I: if (bus.M_ACK || bus.M_RTY || !bus.I_CYC) state_nxt = IDLE;
            GRANT_D: if (bus.M_ACK || bus.M_RTY || !bus.D_CYC) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request mux and response routing; everything is zero in IDLE, and
    // reset forces IDLE asynchronously so outputs drop immediately.
    logic              m_cyc, m_stb, m_we;
    logic [ADDR_W-1:0] m_adr;
    logic [DATA_W-1:0] m_dat;
    logic [SEL_W-1:0]  m_sel;

    always_comb begin
        m_cyc     = 1'b0;
        m_stb     = 1'b0;
        m_we      = 1'b0;
        m_adr     = '0;
        m_dat     = '0;
        m_sel     = '0;
        bus.I_ACK = 1'b0;
        bus.I_RTY = 1'b0;
        bus.D_ACK = 1'b0;
        bus.D_RTY = 1'b0;
        case (state)
            GRANT_I: begin
                m_cyc     = bus.I_CYC;
                m_stb     = bus.I_STB;
                m_we      = bus.I_WE;
                m_adr     = bus.I_ADR;
                m_dat     = bus.I_DAT_M;
                m_sel     = bus.I_SEL;
                bus.I_ACK = bus.M_ACK;
                bus.I_RTY = bus.M_RTY;
            end
            GRANT_D: begin
                m_cyc     = bus.D_CYC;
                m_stb     = bus.D_STB;
                m_we      = bus.D_WE;
                m_adr     = bus.D_ADR;
                m_dat     = bus.D_DAT_M;
                m_sel     = bus.D_SEL;
                bus.D_ACK = bus.M_ACK;
                bus.D_RTY = bus.M_RTY;
            end
            default: ;
        endcase
    end

    assign bus.M_CYC   = m_cyc;
    assign bus.M_STB   = m_stb;
    assign bus.M_WE    = m_we;
    assign bus.M_ADR   = m_adr;
    assign bus.M_DAT_M = m_dat;
    assign bus.M_SEL   = m_sel;

    // Read data is broadcast; each master qualifies it with its own ACK.
    assign bus.I_DAT_S = bus.M_DAT_S;
    assign bus.D_DAT_S = bus.M_DAT_S;
endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    localparam int SEL_W  = DATA_W / 8;
    localparam logic [ADDR_W-1:0] AI = 28'h0000111;
    localparam logic [ADDR_W-1:0] AD = 28'h0000222;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    typedef logic [511:0] w_t;

    typedef struct packed {
        logic              i_req, d_req, ack, rty;
        logic              m_cyc;
        logic [ADDR_W-1:0] m_adr;
        logic              i_ack, i_rty, d_ack, d_rty;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    wb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: who currently owns the memory port (0 none, 1 I, 2 D)
    // and who was served most recently.
    int owner, last;

    task automatic check(input string name, input w_t act, input w_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rdat();
        return DATA_W'({$urandom, $urandom, $urandom, $urandom});
    endfunction

    task automatic clr();
        bus.I_CYC = 0; bus.I_STB = 0; bus.I_WE = 0; bus.I_ADR = '0; bus.I_DAT_M = '0; bus.I_SEL = '0;
        bus.D_CYC = 0; bus.D_STB = 0; bus.D_WE = 0; bus.D_ADR = '0; bus.D_DAT_M = '0; bus.D_SEL = '0;
        bus.M_ACK = 0; bus.M_RTY = 0; bus.M_DAT_S = '0;
    endtask

    function automatic w_t pack_act();
        return w_t'({bus.M_CYC, bus.M_STB, bus.M_WE, bus.M_SEL, bus.M_ADR, bus.M_DAT_M,
                     bus.I_ACK, bus.I_RTY, bus.D_ACK, bus.D_RTY, bus.I_DAT_S, bus.D_DAT_S});
    endfunction

    function automatic w_t pack_exp(input int own);
        logic c, s, w, ia, ir, da, dr;
        logic [SEL_W-1:0]  sel;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        c = 0; s = 0; w = 0; ia = 0; ir = 0; da = 0; dr = 0; sel = '0; a = '0; d = '0;
        if (own == 1) begin
            c = bus.I_CYC; s = bus.I_STB; w = bus.I_WE; sel = bus.I_SEL; a = bus.I_ADR; d = bus.I_DAT_M;
            ia = bus.M_ACK; ir = bus.M_RTY;
        end else if (own == 2) begin
            c = bus.D_CYC; s = bus.D_STB; w = bus.D_WE; sel = bus.D_SEL; a = bus.D_ADR; d = bus.D_DAT_M;
            da = bus.M_ACK; dr = bus.M_RTY;
        end
        return w_t'({c, s, w, sel, a, d, ia, ir, da, dr, bus.M_DAT_S, bus.M_DAT_S});
    endfunction

    task automatic model_edge();
        bit ir, dr;
        ir = bus.I_CYC & bus.I_STB;
        dr = bus.D_CYC & bus.D_STB;
        if (owner == 0) begin
            if (ir && dr) owner = (last == 1) ? 2 : 1;
            else if (ir)  owner = 1;
            else if (dr)  owner = 2;
            if (owner != 0) last = owner;
        end else if (bus.M_ACK || bus.M_RTY || (owner == 1 ? !bus.I_CYC : !bus.D_CYC)) begin
            owner = 0;
        end
    endtask

    // Holds reset for two edges with live requests and a stray ACK, checks
    // that everything stays quiet, then releases it just after an edge.
    task automatic do_reset();
        rst = 1;
        clr();
        bus.I_CYC = 1; bus.I_STB = 1; bus.D_CYC = 1; bus.D_STB = 1;
        bus.I_ADR = AI; bus.D_ADR = AD; bus.M_ACK = 1; bus.M_DAT_S = rdat();
        next();
        next();
        check("reset_outputs", pack_act(), pack_exp(0));
        clr();
        rst = 0;
        owner = 0;
        last = 1;
    endtask

    vec_t tbl [15];
    int   got [$];

    initial begin
        rst = 1;
        clr();
        next();

        // ---- Table: simultaneous requests, stray ACK, ACK+RTY, RTY ----
        tbl[0]  = '{H, H, L, L, L, '0, L, L, L, L};
        tbl[1]  = '{H, H, L, L, H, AD, L, L, L, L};
        tbl[2]  = '{H, H, L, L, H, AD, L, L, L, L};
        tbl[3]  = '{H, H, H, L, H, AD, L, L, H, L};
        tbl[4]  = '{H, H, L, L, L, '0, L, L, L, L};
        tbl[5]  = '{H, H, L, L, H, AI, L, L, L, L};
        tbl[6]  = '{H, H, L, L, H, AI, L, L, L, L};
        tbl[7]  = '{H, H, H, L, H, AI, H, L, L, L};
        tbl[8]  = '{H, H, H, L, L, '0, L, L, L, L};
        tbl[9]  = '{H, H, H, H, H, AD, L, L, H, H};
        tbl[10] = '{L, L, L, L, L, '0, L, L, L, L};
        tbl[11] = '{H, L, L, H, L, '0, L, L, L, L};
        tbl[12] = '{H, L, L, H, H, AI, L, H, L, L};
        tbl[13] = '{L, H, L, L, L, '0, L, L, L, L};
        tbl[14] = '{L, H, L, L, H, AD, L, L, L, L};

        do_reset();
        for (int k = 0; k < 15; k++) begin
            bus.I_ADR = AI; bus.D_ADR = AD;
            bus.I_CYC = tbl[k].i_req; bus.I_STB = tbl[k].i_req;
            bus.D_CYC = tbl[k].d_req; bus.D_STB = tbl[k].d_req;
            bus.M_ACK = tbl[k].ack;   bus.M_RTY = tbl[k].rty;
            #3;
            check($sformatf("table[%0d]", k),
                  w_t'({bus.M_CYC, bus.M_ADR, bus.I_ACK, bus.I_RTY, bus.D_ACK, bus.D_RTY}),
                  w_t'({tbl[k].m_cyc, tbl[k].m_adr, tbl[k].i_ack, tbl[k].i_rty, tbl[k].d_ack, tbl[k].d_rty}));
            next();
        end

        // ---- Single I read ----
        do_reset();
        bus.I_CYC = 1; bus.I_STB = 1; bus.I_ADR = 28'h0000123;
        #3 check("read_c0_cyc", w_t'(bus.M_CYC), w_t'(0));
        next();
        #3 check("read_c1_adr", w_t'({bus.M_CYC, bus.M_ADR, bus.I_ACK}), w_t'({1'b1, 28'h0000123, 1'b0}));
        next();
        next();
        bus.M_ACK = 1; bus.M_DAT_S = {16{8'hA5}};
        #3 check("read_c3_ack", w_t'({bus.M_ADR, bus.I_ACK, bus.D_ACK, bus.I_DAT_S}),
                 w_t'({28'h0000123, 1'b1, 1'b0, {16{8'hA5}}}));
        next();
        bus.M_ACK = 0;
        #3 check("read_c4_idle", w_t'(bus.M_CYC), w_t'(0));
        clr();
        next();

        // ---- D write ended by retry ----
        bus.D_CYC = 1; bus.D_STB = 1; bus.D_WE = 1; bus.D_SEL = 16'hFFFF;
        bus.D_DAT_M = 128'h1; bus.D_ADR = AD;
        next();
        bus.M_RTY = 1;
        #3 check("write_fields", w_t'({bus.M_WE, bus.M_SEL, bus.M_DAT_M, bus.D_RTY, bus.D_ACK, bus.I_RTY}),
                 w_t'({1'b1, 16'hFFFF, 128'h1, 1'b1, 1'b0, 1'b0}));
        next();
        bus.M_RTY = 0;
        #3 check("write_idle", w_t'(bus.M_CYC), w_t'(0));
        clr();
        next();

        // ---- Abort: I drops CYC in its second granted cycle ----
        bus.I_CYC = 1; bus.I_STB = 1; bus.I_ADR = AI;
        next();
        #3 check("abort_grant", w_t'(bus.M_CYC), w_t'(1));
        next();
        bus.I_CYC = 0; bus.I_STB = 0;
        #3 check("abort_drop", w_t'(bus.M_CYC), w_t'(0));
        next();
        bus.I_CYC = 1; bus.I_STB = 1;
        #3 check("abort_idle", w_t'(bus.M_CYC), w_t'(0));
        next();
        #3 check("abort_regrant", w_t'({bus.M_CYC, bus.M_ADR}), w_t'({1'b1, AI}));
        clr();
        bus.M_ACK = 1;
        next();
        clr();
        next();

        // ---- Reset pulse in the middle of GRANT_D ----
        bus.D_CYC = 1; bus.D_STB = 1; bus.D_ADR = AD;
        next();
        #3 check("rstmid_grant", w_t'(bus.M_CYC), w_t'(1));
        next();
        bus.M_ACK = 1;
        rst = 1;
        #1 check("rstmid_async", w_t'({bus.M_CYC, bus.D_ACK}), w_t'(0));
        next();
        #3 check("rstmid_held", w_t'({bus.M_CYC, bus.D_ACK}), w_t'(0));
        next();
        rst = 0; bus.M_ACK = 0;
        #3 check("rstmid_idle", w_t'(bus.M_CYC), w_t'(0));
        next();
        #3 check("rstmid_regrant", w_t'({bus.M_CYC, bus.M_ADR}), w_t'({1'b1, AD}));
        clr();

        // ---- Fairness: both request continuously ----
        do_reset();
        got.delete();
        for (int c = 0; c < 40 && got.size() < 6; c++) begin
            bus.I_CYC = 1; bus.I_STB = 1; bus.I_ADR = AI;
            bus.D_CYC = 1; bus.D_STB = 1; bus.D_ADR = AD;
            bus.M_ACK = 0;
            #3;
            if (bus.M_CYC) begin
                got.push_back(bus.M_ADR == AD ? 2 : 1);
                bus.M_ACK = 1;
            end
            next();
        end
        for (int k = 0; k < 6; k++)
            check($sformatf("fair[%0d]", k), w_t'(k < got.size() ? got[k] : 0), w_t'((k % 2 == 0) ? 2 : 1));
        clr();

        // ---- Randomized traffic against the reference model ----
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bus.I_CYC = ($urandom_range(0, 3) != 0); bus.I_STB = ($urandom_range(0, 3) != 0);
            bus.I_WE = 1'($urandom); bus.I_ADR = ADDR_W'($urandom);
            bus.I_DAT_M = rdat(); bus.I_SEL = SEL_W'($urandom);
            bus.D_CYC = ($urandom_range(0, 3) != 0); bus.D_STB = ($urandom_range(0, 3) != 0);
            bus.D_WE = 1'($urandom); bus.D_ADR = ADDR_W'($urandom);
            bus.D_DAT_M = rdat(); bus.D_SEL = SEL_W'($urandom);
            bus.M_ACK = ($urandom_range(0, 2) == 0); bus.M_RTY = ($urandom_range(0, 7) == 0);
            bus.M_DAT_S = rdat();
            #3 check($sformatf("rand[%0d]", c), pack_act(), pack_exp(owner));
            model_edge();
            next();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
